// File: rtl/score_ram_ahb_if.sv
// score_ram_ahb_if: AHB-Lite slave bus bundle for the score RAM
interface score_ram_ahb_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  modport master (output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY, input HREADYOUT, HRDATA, HRESP);
  modport slave (input HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY, output HREADYOUT, HRDATA, HRESP);
endinterface

// File: rtl/score_ram_ahb.sv
// score_ram_ahb: AHB-Lite word RAM with programmable wait states; define SCORE_RAM_ERR_EN for range/alignment error responses
module score_ram_ahb #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input logic clk,
  input logic rst_n,
  score_ram_ahb_if.slave s
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
  state_t state, nxt;
  logic [ADDR_WIDTH-1:0] a_addr, rd_addr;
  logic [1:0] a_lo, wcnt;
  logic [2:0] a_size;
  logic a_write, acc, err, last, wr, ld;
  logic [3:0] be;
  logic [31:0] rd_word;
  logic [31:0] mem [2**ADDR_WIDTH];
  assign acc = s.HSEL & s.HREADY & s.HTRANS[1];
`ifdef SCORE_RAM_ERR_EN
  assign err = (|(s.HADDR[15:0] >> (ADDR_WIDTH + 2))) | (s.HSIZE == 3'd1 & s.HADDR[0]) | (s.HSIZE == 3'd2 & |s.HADDR[1:0]);
`else
  assign err = 1'b0;
`endif
  assign last = wcnt == 2'(WAIT_STATES - 1);
  assign wr = state == S_DATA && a_write;
  assign be = a_size == 3'd0 ? 4'b0001 << a_lo : a_size == 3'd1 ? (a_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  // zero-wait reads sample the RAM at accept time; otherwise at the end of the wait window
  assign rd_addr = WAIT_STATES == 0 ? s.HADDR[ADDR_WIDTH+1:2] : a_addr;
  assign ld = WAIT_STATES == 0 ? acc && !err && !s.HWRITE : state == S_WAIT && last && !a_write;
  // read word with lanes of a write committing on the same edge forwarded in
  always_comb begin
    rd_word = mem[rd_addr];
    for (int i = 0; i < 4; i++) if (wr && be[i] && a_addr == rd_addr) rd_word[8*i +: 8] = s.HWDATA[8*i +: 8];
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  // next state: waits and error beats run to completion, otherwise follow the address phase
  always_comb begin
    nxt = state == S_WAIT ? (last ? S_DATA : S_WAIT) :
          state == S_ERR1 ? S_ERR2 :
          !acc ? S_IDLE :
          err ? S_ERR1 :
          WAIT_STATES > 0 ? S_WAIT : S_DATA;
  end
  // bus response outputs
  always_comb begin
    s.HREADYOUT = !(state == S_WAIT || state == S_ERR1);
    s.HRESP = state == S_ERR1 || state == S_ERR2;
  end
  // address-phase capture and wait counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_addr <= '0;
      a_lo <= '0;
      a_size <= '0;
      a_write <= 1'b0;
      wcnt <= '0;
    end else begin
      wcnt <= acc ? 2'd0 : wcnt + 2'd1;
      if (acc) begin
        a_addr <= s.HADDR[ADDR_WIDTH+1:2];
        a_lo <= s.HADDR[1:0];
        a_size <= s.HSIZE;
        a_write <= s.HWRITE;
      end
    end
  // read data register, held between read data phases
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s.HRDATA <= '0;
    else if (ld) s.HRDATA <= rd_word;
  // byte-enabled write at the end of a write data phase; contents survive reset
  always_ff @(posedge clk)
    if (wr) for (int i = 0; i < 4; i++) if (be[i]) mem[a_addr][8*i +: 8] <= s.HWDATA[8*i +: 8];
endmodule
